gpu_stencil_ctrl: RTL

GPU_STENCIL_CTRL -- requirements
Module: gpu_stencil_ctrl

---
 rtl/gpu_stencil_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/gpu_stencil_ctrl.sv
// Stencil cache front end: passes pixel-pipe accesses through when idle and runs masked rectangle fills.
// Fill writes one word per cycle; pixel requests are refused (pix_ready_o=0) while a fill is running.
module gpu_stencil_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pix_rd_req_i,
    input  logic [14:0] pix_rd_addr_i,
    input  logic        pix_wr_req_i,
    input  logic [14:0] pix_wr_addr_i,
    input  logic [15:0] pix_wr_mask_i,
    input  logic [15:0] pix_wr_value_i,
    output logic        pix_ready_o,
    output logic [15:0] pix_rd_value_o,
    output logic        pix_rd_valid_o,
    input  logic        fill_start_i,
    input  logic [9:0]  fill_x_i,
    input  logic [8:0]  fill_y_i,
    input  logic [10:0] fill_w_i,
    input  logic [9:0]  fill_h_i,
    input  logic        fill_value_i,
    output logic        fill_busy_o,
    output logic        fill_done_o,
    output logic        stencil_rd_req_o,
    output logic [14:0] stencil_rd_addr_o,
    output logic        stencil_wr_req_o,
    output logic [14:0] stencil_wr_addr_o,
    output logic [15:0] stencil_wr_mask_o,
    output logic [15:0] stencil_wr_value_o,
    input  logic [15:0] stencil_rd_value_i
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [9:0]  x_q;
    logic [10:0] w_q;
    logic [9:0]  h_q;
    logic        v_q;
    logic [6:0]  kmax_q;
    logic [8:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic [6:0]  k_q, k_d;
    logic [9:0]  rcnt_q, rcnt_d;
    logic        rd_vld_q;

    logic        idle;
    logic        fill_act;
    logic [10:0] w_clamp;
    logic [9:0]  h_clamp;
    logic [6:0]  k_calc;
    logic [15:0] fill_mask;
    logic [9:0]  pix_off;

    assign idle     = (state_q == IDLE);
    assign fill_act = (state_q == FILL);
    assign w_clamp  = (fill_w_i > 11'd1024) ? 11'd1024 : fill_w_i;
    assign h_clamp  = (fill_h_i > 10'd512) ? 10'd512 : fill_h_i;
    // Words per row: ceil((x[3:0] + w) / 16); at most 65 for an unaligned full-width row.
    assign k_calc   = 7'(({7'd0, fill_x_i[3:0]} + w_clamp + 11'd15) >> 4);

    // A bit is inside the rectangle when its offset from x (wrapping at 1024) is below w.
    always_comb begin
        fill_mask = '0;
        pix_off   = '0;
        for (int b = 0; b < 16; b++) begin
            pix_off      = {col_q, 4'(b)} - x_q;
            fill_mask[b] = ({1'b0, pix_off} < w_q);
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        rcnt_d  = rcnt_q;
        case (state_q)
            IDLE: begin
                if (fill_start_i) begin
                    row_d   = fill_y_i;
                    col_d   = fill_x_i[9:4];
                    k_d     = '0;
                    rcnt_d  = '0;
                    state_d = (w_clamp == 11'd0 || h_clamp == 10'd0) ? DONE : FILL;
                end
            end
            FILL: begin
                if (k_q == kmax_q - 7'd1) begin
                    k_d    = '0;
                    col_d  = x_q[9:4];
                    row_d  = row_q + 9'd1;
                    rcnt_d = rcnt_q + 10'd1;
                    if (rcnt_q == h_q - 10'd1) state_d = DONE;
                end else begin
                    k_d   = k_q + 7'd1;
                    col_d = col_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            x_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            v_q      <= 1'b0;
            kmax_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            rcnt_q   <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            k_q      <= k_d;
            rcnt_q   <= rcnt_d;
            rd_vld_q <= idle & pix_rd_req_i;
            if (idle && fill_start_i) begin
                x_q    <= fill_x_i;
                w_q    <= w_clamp;
                h_q    <= h_clamp;
                v_q    <= fill_value_i;
                kmax_q <= k_calc;
            end
        end
    end

    assign pix_ready_o        = idle;
    assign pix_rd_valid_o     = rd_vld_q;
    assign pix_rd_value_o     = stencil_rd_value_i;
    assign fill_busy_o        = !idle;
    assign fill_done_o        = (state_q == DONE);
    assign stencil_rd_req_o   = idle & pix_rd_req_i;
    assign stencil_rd_addr_o  = pix_rd_addr_i;
    assign stencil_wr_req_o   = idle ? pix_wr_req_i   : fill_act;
    assign stencil_wr_addr_o  = idle ? pix_wr_addr_i  : {row_q, col_q};
    assign stencil_wr_mask_o  = idle ? pix_wr_mask_i  : fill_mask;
    assign stencil_wr_value_o = idle ? pix_wr_value_i : {16{v_q}};
endmodule
